// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter.
//   state_t : arbiter FSM states (IDLE -> ACCESS -> RESP)
//   owner_t : which requester owns the access currently in flight
//   WAIT_W  : width of the fetch starvation counter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    localparam int WAIT_W = 3;

endpackage

// File: rtl/fetch_wait_counter.sv
// Saturating count of consecutive ticks on which a fetch request was
// pending but not granted. The arbiter uses o_at_max to let fetch
// override the normal data-first priority.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   i_tick       : clock qualifier; the count only moves on ticks
//   i_fetch_req  : fetch request level
//   i_fetch_win  : fetch is being granted on this tick
//   o_count      : current count
//   o_at_max     : count equals MAX_FETCH_WAIT
module fetch_wait_counter
    import mem_arb_pkg::*;
#(
    parameter int MAX_FETCH_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_tick,
    input  logic              i_fetch_req,
    input  logic              i_fetch_win,
    output logic [WAIT_W-1:0] o_count,
    output logic              o_at_max
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_FETCH_WAIT);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_tick) begin
            if (!i_fetch_req || i_fetch_win)
                r_count <= '0;
            else if (r_count != MAX_CNT)
                r_count <= r_count + 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and
// load/store. Each access takes three ticks: IDLE (grant + command
// registered), ACCESS (command held on the memory port), RESP (read data
// captured, response pulse). Data wins over fetch unless fetch has been
// starved for MAX_FETCH_WAIT ticks.
// Ports:
//   clk, rst_n, clk_enable           : clock, async active-low reset, tick qualifier
//   fetch_req/fetch_addr/fetch_flush : fetch request, word address, cancel in-flight fetch
//   data_req/data_we/data_addr/data_wdata : load/store request
//   mem_rdata                        : memory read data (valid during RESP)
//   fetch_gnt, data_gnt              : one-tick grant pulses
//   mem_en/mem_we/mem_addr/mem_wdata : registered memory command
//   fetch_rvalid, data_done, rdata   : response pulses and captured read data
//   busy                             : FSM not in IDLE
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_FETCH_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_enable,
    input  logic        fetch_req,
    input  logic [29:0] fetch_addr,
    input  logic        fetch_flush,
    input  logic        data_req,
    input  logic        data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [31:0] mem_rdata,
    output logic        fetch_gnt,
    output logic        data_gnt,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        fetch_rvalid,
    output logic        data_done,
    output logic [31:0] rdata,
    output logic        busy
);

    state_t            r_state, w_state_nxt;
    owner_t            r_owner;
    logic              r_flushed;
    logic              r_fetch_gnt, r_data_gnt;
    logic              r_mem_en, r_mem_we;
    logic [31:0]       r_mem_addr, r_mem_wdata;
    logic              r_fetch_rvalid, r_data_done;
    logic [31:0]       r_rdata;

    logic              w_idle;
    logic              w_fetch_win, w_data_win;
    logic              w_wait_max;
    logic [WAIT_W-1:0] w_wait_cnt;

    assign w_idle      = (r_state == IDLE);
    // Data first, unless fetch has been starved to the limit.
    assign w_fetch_win = w_idle && fetch_req && (!data_req || w_wait_max);
    assign w_data_win  = w_idle && data_req && !w_fetch_win;

    fetch_wait_counter #(
        .MAX_FETCH_WAIT (MAX_FETCH_WAIT)
    ) u_wait (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_tick      (clk_enable),
        .i_fetch_req (fetch_req),
        .i_fetch_win (w_fetch_win),
        .o_count     (w_wait_cnt),
        .o_at_max    (w_wait_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else if (clk_enable)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (fetch_req || data_req) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner        <= FETCH;
            r_flushed      <= 1'b0;
            r_fetch_gnt    <= 1'b0;
            r_data_gnt     <= 1'b0;
            r_mem_en       <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_fetch_rvalid <= 1'b0;
            r_data_done    <= 1'b0;
            r_rdata        <= '0;
        end else if (clk_enable) begin
            // Pulses default low each tick; stalled ticks hold them.
            r_fetch_gnt    <= w_fetch_win;
            r_data_gnt     <= w_data_win;
            r_fetch_rvalid <= 1'b0;
            r_data_done    <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_flushed <= 1'b0;
                    if (w_fetch_win) begin
                        r_owner     <= FETCH;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= {fetch_addr, 2'b00};
                        r_mem_wdata <= '0;
                    end else if (w_data_win) begin
                        r_owner     <= DATA;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= data_we;
                        r_mem_addr  <= data_addr;
                        r_mem_wdata <= data_wdata;
                    end
                end
                ACCESS: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (r_owner == FETCH && fetch_flush)
                        r_flushed <= 1'b1;
                end
                RESP: begin
                    r_rdata   <= mem_rdata;
                    r_flushed <= 1'b0;
                    // A flush arriving on the RESP tick itself still cancels.
                    if (r_owner == FETCH)
                        r_fetch_rvalid <= !(r_flushed || fetch_flush);
                    else
                        r_data_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fetch_gnt    = r_fetch_gnt;
    assign data_gnt     = r_data_gnt;
    assign mem_en       = r_mem_en;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign fetch_rvalid = r_fetch_rvalid;
    assign data_done    = r_data_done;
    assign rdata        = r_rdata;
    assign busy         = !w_idle;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_FETCH_WAIT, default 4, meaning consecutive denied fetch ticks before fetch is forced to win.
REQ-002 SHALL have ports: clk  in  1  system clock; one clock domain only.
REQ-003 SHALL have ports: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: clk_enable  in  1  tick qualifier; state advances only on clk edges where clk_enable=1 ("tick").
REQ-005 SHALL have ports: fetch_req  in  1  instruction fetch request, held until fetch_gnt.
REQ-006 SHALL have ports: fetch_addr  in  30  word address (pc).
REQ-007 SHALL have ports: fetch_flush  in  1  cancel any in-flight fetch (taken branch/jump).
REQ-008 SHALL have ports: data_req  in  1  load/store request, held until data_gnt.
REQ-009 SHALL have ports: data_we  in  1  1=store; data_addr  in  32  byte address; data_wdata  in  32  store data.
REQ-010 SHALL have ports: mem_rdata  in  32  memory read data, valid one tick after the access tick.
REQ-011 SHALL have ports: fetch_gnt, data_gnt  out  1 each  one-tick pulse, request consumed.
REQ-012 SHALL have ports: mem_en, mem_we  out  1 each; mem_addr  out  32; mem_wdata  out  32  registered memory command.
REQ-013 SHALL have ports: fetch_rvalid  out  1; data_done  out  1; rdata  out  32  response pulse and captured read data.
REQ-014 SHALL have ports: busy  out  1  high whenever state != IDLE (pipeline stall source).

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESP, one transition per tick; RESP returns to IDLE.
REQ-016 SHALL, in IDLE with any request on a tick, pick a winner, register mem_addr/mem_we/mem_wdata, set mem_en=1, pulse the winner's gnt, and enter ACCESS.
REQ-017 SHALL drive fetch commands as mem_addr={fetch_addr,2'b00}, mem_we=0; data commands as data_addr, data_we, data_wdata.
REQ-018 SHALL hold mem_en/mem_we/mem_addr/mem_wdata stable through ACCESS and clear mem_en/mem_we on leaving ACCESS.
REQ-019 SHALL, in RESP, capture mem_rdata into rdata and pulse fetch_rvalid (fetch access) or data_done (data access, load or store) for exactly one tick.
REQ-020 SHALL prioritise data over fetch, except when the fetch wait counter equals MAX_FETCH_WAIT, in which case fetch wins.
REQ-021 SHALL increment the 3-bit wait counter on each tick with fetch_req=1 and no fetch grant, saturating at MAX_FETCH_WAIT; it SHALL clear on fetch grant or on fetch_req=0.
REQ-022 SHALL, when fetch_flush=1 on a tick while a fetch is in ACCESS or RESP, suppress that fetch's fetch_rvalid; the memory access still completes and timing is unchanged.
REQ-023 SHALL ignore fetch_flush while a data access is in flight.
REQ-024 SHALL ignore requests outside IDLE; gnt pulses only leave IDLE, so a request is never granted twice.
REQ-025 SHALL hold all state and outputs unchanged on clk edges with clk_enable=0, including one-tick pulses, which span the full enable period.
REQ-026 SHALL keep each access at 3 ticks (grant to response), giving throughput of one access per 3 ticks.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously force state=IDLE, wait counter=0, and all outputs to 0 (rdata=32'h0, mem_addr=32'h0).
REQ-028 SHALL abandon any access in flight at reset with no response pulse, and accept a new request on the first tick after rst_n rises.

Structure
REQ-029 SHALL put the state enum (IDLE/ACCESS/RESP), the owner enum (FETCH/DATA) and the wait-counter width in shared package mem_arb_pkg.
REQ-030 SHALL place the saturating wait counter in one sub-module, fetch_wait_counter; all other logic stays flat.

Verification
REQ-031 SHALL check single fetch: fetch_req, fetch_addr=30'h10 in IDLE -> fetch_gnt at tick 0, mem_addr=32'h40 with mem_en at tick 1, fetch_rvalid with rdata=mem_rdata at tick 2.
REQ-032 SHALL check collision: fetch_req and data_req (load, addr 32'h100) together -> data_gnt first, then fetch_gnt at the next IDLE tick.
REQ-033 SHALL check starvation: fetch_req held with data_req continuously asserted -> fetch_gnt no later than the IDLE after the counter reaches 4, then the counter reads 0.
REQ-034 SHALL check store: data_we=1, data_addr=32'h8, data_wdata=32'hDEADBEEF -> mem_we=1 with those values for one access, then data_done pulse and no fetch_rvalid.
REQ-035 SHALL check flush: fetch_flush=1 during fetch ACCESS -> no fetch_rvalid, busy falls after RESP, and the next fetch_req is granted normally.
REQ-036 SHALL check reset: rst_n=0 during RESP -> immediately state IDLE, all outputs 0, no pulse; clk_enable=0 stalls -> outputs frozen.
